mips_run_ctrl: RTL



---
 rtl/mips_run_pkg.sv | 21 ++
 rtl/mips_run_ctrl_run_tick_gen.sv | 33 +++
 rtl/mips_run_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_run_pkg.sv
// Shared encodings for the DE10-Lite MIPS run controller: FSM states,
// speed codes and button bit positions.
package mips_run_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] SPD_2HZ  = 2'd0;
    localparam logic [1:0] SPD_20HZ = 2'd1;
    localparam logic [1:0] SPD_1KHZ = 2'd2;
    localparam logic [1:0] SPD_FULL = 2'd3;

    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int BTN_SPD  = 2;
    localparam int BTN_DISP = 3;

endpackage

// File: rtl/mips_run_ctrl_run_tick_gen.sv
// Run-rate prescaler: counts 0..period-1 while enabled and flags the last
// count as a tick; clr restarts the count from zero on the next edge.
module run_tick_gen #(
    parameter int CW = 25
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] period_i,
    output logic          tick_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == period_i - CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: halt / single-step / free-run CPU clock-enable, speed and
// display-page selection, executed-instruction counter. BRKPT_EN adds a PC breakpoint.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int DIV0 = 25000000,
    parameter int DIV1 = 2500000,
    parameter int DIV2 = 50000,
    parameter int DIV3 = 1,
    parameter int CW   = 25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  BTN,
    input  logic        HALT_REQ,
    input  logic [31:0] PC,
    input  logic [31:0] BRK_ADDR,
    output logic        CPU_EN,
    output logic        RUNNING,
    output logic [1:0]  SPEED,
    output logic [1:0]  DISP_SEL,
    output logic [31:0] ICOUNT
);

    state_t        state_q;
    logic          cpu_en_q;
    logic          running_q;
    logic [1:0]    speed_q;
    logic [1:0]    disp_q;
    logic [31:0]   icount_q;
    logic [CW-1:0] period;
    logic          tick;
    logic          brk_hit;

    always_comb begin
        period = CW'(DIV0);
        case (speed_q)
            SPD_2HZ:  period = CW'(DIV0);
            SPD_20HZ: period = CW'(DIV1);
            SPD_1KHZ: period = CW'(DIV2);
            SPD_FULL: period = CW'(DIV3);
            default:  period = CW'(DIV0);
        endcase
    end

    // Held clear outside RUN so every run entry starts a full period.
    run_tick_gen #(.CW(CW)) u_tick (
        .CLK      (CLK),
        .RST      (RST),
        .clr_i    (BTN[BTN_SPD] || (state_q != RUN)),
        .en_i     (state_q == RUN),
        .period_i (period),
        .tick_o   (tick)
    );

`ifdef BRKPT_EN
    assign brk_hit = tick && (PC == BRK_ADDR);
`else
    logic unused_brk;
    assign brk_hit    = 1'b0;
    assign unused_brk = ^{PC, BRK_ADDR};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= HALT;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            speed_q   <= SPD_2HZ;
            disp_q    <= 2'd0;
            icount_q  <= 32'd0;
        end else begin
            icount_q <= icount_q + {31'd0, cpu_en_q};
            cpu_en_q <= 1'b0;
            if (BTN[BTN_SPD])
                speed_q <= speed_q + 2'd1;
            if (BTN[BTN_DISP])
                disp_q <= disp_q + 2'd1;
            case (state_q)
                HALT: begin
                    // Run/stop wins over step when both arrive together.
                    if (BTN[BTN_RUN]) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (BTN[BTN_STEP]) begin
                        state_q  <= STEP;
                        cpu_en_q <= 1'b1;
                    end
                end
                STEP: state_q <= HALT;
                RUN: begin
                    if (BTN[BTN_RUN] || HALT_REQ || brk_hit) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                    end else begin
                        cpu_en_q <= tick;
                    end
                end
                default: begin
                    state_q   <= HALT;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign CPU_EN   = cpu_en_q;
    assign RUNNING  = running_q;
    assign SPEED    = speed_q;
    assign DISP_SEL = disp_q;
    assign ICOUNT   = icount_q;

endmodule
